// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller for a 64x8 dual-port RAM with 1-clk registered read, fronted by a 2-entry output buffer.
// Optional: define FIFO_OVF_CNT_EN to add a saturating dropped-write cycle counter (ovf_cnt).
module ram_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int AFULL_LVL = 56
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W:0]   level,
  output logic              almost_full
`ifdef FIFO_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LW    = ADDR_W + 1;

  logic [ADDR_W-1:0]            wptr, rptr;
  logic [LW-1:0]                mem_cnt, mem_cnt_nxt, level_nxt;
  logic [1:0]                   buf_cnt;
  logic [1:0][DATA_W-1:0]       obuf;
  logic                         inflight, not_full;
  logic                         accept, pop, fetch;
  logic [2:0]                   occ;

  assign wr_ready       = rst_n & not_full;
  assign accept         = wr_valid & wr_ready;
  assign pop            = (buf_cnt != 2'd0) & rd_ready;
  assign rd_valid       = buf_cnt != 2'd0;
  assign rd_data        = obuf[0];
  assign ram_we         = accept;
  assign ram_write_addr = wptr;
  assign ram_data       = wr_data;
  assign ram_read_addr  = rptr;

  // Words already headed for the output buffer; a pop this cycle frees one slot.
  assign occ         = {1'b0, buf_cnt} + {2'b0, inflight};
  assign fetch       = (mem_cnt != '0) && (occ < (3'd2 + {2'b0, pop}));
  assign mem_cnt_nxt = mem_cnt + LW'(accept) - LW'(fetch);
  assign level_nxt   = level + LW'(accept) - LW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      mem_cnt     <= '0;
      level       <= '0;
      not_full    <= 1'b1;
      almost_full <= 1'b0;
      inflight    <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (fetch)  rptr <= rptr + 1'b1;
      mem_cnt     <= mem_cnt_nxt;
      level       <= level_nxt;
      not_full    <= mem_cnt_nxt < LW'(DEPTH);
      almost_full <= level_nxt >= LW'(AFULL_LVL);
      inflight    <= fetch;
    end
  end

  // Output buffer: obuf[0] is the head; a capture never finds the buffer full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf    <= '0;
      buf_cnt <= 2'd0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          obuf[buf_cnt[0]] <= ram_q;
          buf_cnt          <= buf_cnt + 2'd1;
        end
        2'b01: begin
          obuf[0] <= obuf[1];
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd2) begin
            obuf[0] <= obuf[1];
            obuf[1] <= ram_q;
          end else begin
            obuf[0] <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_cnt <= 16'd0;
    else if (wr_valid && !wr_ready && ovf_cnt != 16'hFFFF)
      ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Randomized scoreboard bench for ram_fifo_ctrl with a behavioural RAM and a queue reference model.
module tb_ram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int AFULL  = 56;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready = 1'b0;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_write_addr, ram_read_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q = '0;
  logic [ADDR_W:0]   level;
  logic              almost_full;

  ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .ram_we(ram_we),
    .ram_write_addr(ram_write_addr), .ram_data(ram_data), .ram_read_addr(ram_read_addr),
    .ram_q(ram_q), .level(level), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Behavioural 64x8 RAM with registered read.
  logic [DATA_W-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = 8'hEE;
  always @(posedge clk) begin
    if (ram_we) ram[ram_write_addr] <= ram_data;
    ram_q <= ram[ram_read_addr];
  end

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: accepted words are pushed, popped words compared in order.
  logic [DATA_W-1:0] model [$];
  int wcnt = 0;
  int pops = 0;
  int pop_mark = 0;
  int first_pop_cyc = 0, last_pop_cyc = 0;
  logic hold = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      model.delete();
      wcnt = 0;
      hold = 1'b0;
    end else begin
      chk("level", 32'(level), 32'(model.size()));
      chk("almost_full", 32'(almost_full), 32'(model.size() >= AFULL));
      if (model.size() == DEPTH + 2) chk("full_wr_ready", 32'(wr_ready), 0);
      if (hold) begin
        chk("hold_valid", 32'(rd_valid), 1);
        chk("hold_data", 32'(rd_data), 32'(hold_data));
      end
      hold = rd_valid && !rd_ready;
      hold_data = rd_data;
      chk("ram_we", 32'(ram_we), 32'(wr_valid && wr_ready));
      if (rd_valid && rd_ready) begin
        if (model.size() == 0) chk("pop_nonempty", 0, 1);
        else chk("rd_data", 32'(rd_data), 32'(model.pop_front()));
        if (pops == pop_mark) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pops++;
      end
      if (wr_valid && wr_ready) begin
        chk("ram_write_addr", 32'(ram_write_addr), 32'(wcnt % DEPTH));
        chk("ram_data", 32'(ram_data), 32'(wr_data));
        model.push_back(wr_data);
        wcnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    while ((level != 0 || rd_valid) && n < max) begin step(); n++; end
    chk("drain_done", 32'(level == 0 && !rd_valid), 1);
  endtask

  int sent;
  logic acc;
  logic af_high, af_cleared;

  initial begin
    // 1: reset then idle
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_read_addr", 32'(ram_read_addr), 0);

    // 2: single word latency
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    chk("lat_k", 32'(rd_valid), 0);
    step();
    chk("lat_k1", 32'(rd_valid), 0);
    step();
    chk("lat_k2_valid", 32'(rd_valid), 1);
    chk("lat_k2_data", 32'(rd_data), 32'hA5);
    step();
    chk("lat_level", 32'(level), 0);

    // 3: fill to capacity with reader stalled
    rd_ready = 1'b0; wr_valid = 1'b1; sent = 0;
    for (int c = 0; c < 80; c++) begin
      wr_data = DATA_W'(sent);
      acc = wr_ready;
      step();
      if (acc) sent++;
    end
    wr_valid = 1'b0;
    chk("fill_count", 32'(sent), 66);
    chk("fill_wr_ready", 32'(wr_ready), 0);
    chk("fill_level", 32'(level), 66);
    pop_mark = pops;
    drain(100);
    chk("fill_drained", 32'(pops - pop_mark), 66);

    // 4: streaming, 1 word/clk with no bubbles
    rd_ready = 1'b1; pop_mark = pops;
    for (int c = 0; c < 200; c++) begin
      wr_valid = 1'b1; wr_data = DATA_W'($urandom);
      acc = wr_ready;
      step();
      if (!acc) chk("stream_wr_ready", 0, 1);
    end
    drain(20);
    chk("stream_pops", 32'(pops - pop_mark), 200);
    chk("stream_no_bubble", 32'(last_pop_cyc - first_pop_cyc), 199);

    // 5: random stalls, push level through the almost_full threshold and back
    af_high = 1'b0; af_cleared = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c < 300) begin
        wr_valid = ($urandom % 10) < 9; rd_ready = ($urandom % 10) < 2;
      end else begin
        wr_valid = ($urandom % 10) < 2; rd_ready = ($urandom % 10) < 9;
      end
      wr_data = DATA_W'($urandom);
      step();
      if (almost_full) af_high = 1'b1;
      else if (af_high) af_cleared = 1'b1;
    end
    chk("af_seen_high", 32'(af_high), 1);
    chk("af_seen_clear", 32'(af_cleared), 1);
    drain(200);

    // 6: reset while holding 10 words
    rd_ready = 1'b0; wr_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin wr_data = DATA_W'(8'h30 + c); step(); end
    wr_valid = 1'b0;
    step();
    chk("pre_rst_level", 32'(level), 10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_valid", 32'(rd_valid), 0);
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_af", 32'(almost_full), 0);
    chk("mid_rst_ram_we", 32'(ram_we), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    wr_valid = 1'b1; wr_data = 8'h5C;
    #1;
    chk("post_rst_we", 32'(ram_we), 1);
    chk("post_rst_addr", 32'(ram_write_addr), 0);
    step();
    drain(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
